// File: rtl/cpu_pkg.sv
// Shared opcode map, step-state encoding and control-strobe bundle for the
// hardwired control sequencer.
package cpu_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } step_t;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlow_out;
    logic c_out;
    logic read;
    logic write;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic con_in;
  } ctrl_t;

  function automatic logic is_alu_rr(input logic [OPCODE_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction

  function automatic logic is_alu_imm(input logic [OPCODE_W-1:0] op);
    return op inside {OP_ADDI, OP_ANDI, OP_ORI};
  endfunction

  // Opcodes whose T3-T4 form the base+displacement address.
  function automatic logic is_addr(input logic [OPCODE_W-1:0] op);
    return op inside {OP_LDI, OP_LD, OP_ST};
  endfunction

  function automatic logic is_supported(input logic [OPCODE_W-1:0] op);
    return is_alu_rr(op) || is_alu_imm(op) || is_addr(op) ||
           (op inside {OP_BR, OP_JR, OP_NOP, OP_HALT});
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting in a memory step; flags timeout when the count
// reaches MEM_TIMEOUT and memory still has not answered.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  assign timeout = active && !mem_ready && (count == CNT_W'(MEM_TIMEOUT));

  // Any cycle that is not a held wait (ready, timeout, or outside a step) clears.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (active && !mem_ready && !timeout) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, opcode-specific T3-T7, memory wait
// states with timeout, and a HALT state left only through reset.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OP_W        = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [OP_W-1:0] OP,
  input  logic            CON_out,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Cout,
  output logic            Read,
  output logic            Write,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            CONin,
  output logic [OP_W-1:0] alu_op,
  output logic            run,
  output logic            illegal_op,
  output logic            bus_error
);

  step_t                state;
  step_t                state_next;
  logic [OPCODE_W-1:0]  op;
  ctrl_t                ctrl;
  ctrl_t                ctrl_out;
  logic                 alu_add;
  logic                 mem_step;
  logic                 timeout;

  assign op = OPCODE_W'(OP);

  always_comb begin
    ctrl    = '0;
    alu_add = 1'b0;
    case (state)
      T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
        alu_add = 1'b1;
      end
      T1: begin
        ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
      end
      T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
      end
      T3: begin
        if (is_alu_rr(op) || is_alu_imm(op)) begin
          ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
        end else if (is_addr(op)) begin
          ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
        end else if (op == OP_BR) begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1;
        end else if (op == OP_JR) begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
        end
      end
      T4: begin
        if (is_alu_rr(op)) begin
          ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
        end else if (is_alu_imm(op)) begin
          ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
        end else if (is_addr(op)) begin
          ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
          alu_add = 1'b1;
        end else if (op == OP_BR) begin
          ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1;
        end
      end
      T5: begin
        if (is_alu_rr(op) || is_alu_imm(op) || op == OP_LDI) begin
          ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end else if (op == OP_LD || op == OP_ST) begin
          ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
        end else if (op == OP_BR) begin
          ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
          alu_add = 1'b1;
        end
      end
      T6: begin
        if (op == OP_LD) begin
          ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
        end else if (op == OP_ST) begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
        end else if (op == OP_BR) begin
          ctrl.zlow_out = 1'b1; ctrl.pc_in = CON_out;
        end
      end
      T7: begin
        if (op == OP_LD) begin
          ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end else if (op == OP_ST) begin
          ctrl.write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign mem_step = run && ((state == T1) ||
                            (state == T6 && op == OP_LD) ||
                            (state == T7 && op == OP_ST));

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .active   (mem_step),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  always_comb begin
    state_next = state;
    case (state)
      T0: state_next = T1;
      T1: begin
        if (mem_ready)    state_next = T2;
        else if (timeout) state_next = HALT;
      end
      T2: state_next = T3;
      T3: begin
        if (op == OP_HALT)
          state_next = HALT;
        else if (is_alu_rr(op) || is_alu_imm(op) || is_addr(op) || op == OP_BR)
          state_next = T4;
        else
          state_next = T0;
      end
      T4: state_next = T5;
      T5: state_next = (op == OP_LD || op == OP_ST || op == OP_BR) ? T6 : T0;
      T6: begin
        if (op == OP_LD) begin
          if (mem_ready)    state_next = T7;
          else if (timeout) state_next = HALT;
        end else if (op == OP_ST) begin
          state_next = T7;
        end else begin
          state_next = T0;
        end
      end
      T7: begin
        if (op == OP_ST) begin
          if (mem_ready)    state_next = T0;
          else if (timeout) state_next = HALT;
        end else begin
          state_next = T0;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = T0;
    endcase
  end

  // The first clock after reset release only raises run; T0 then starts with
  // run already high, so strobes can be qualified by run alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= T0;
      run       <= 1'b0;
      bus_error <= 1'b0;
    end else if (!run) begin
      if (state != HALT) run <= 1'b1;
    end else begin
      state <= state_next;
      run   <= (state_next != HALT);
      if (timeout) bus_error <= 1'b1;
    end
  end

  assign ctrl_out   = run ? ctrl : '0;
  assign illegal_op = run && (state == T3) && !is_supported(op);
  assign alu_op     = alu_add ? OP_W'(OP_ADD) : OP;

  assign PCout   = ctrl_out.pc_out;
  assign PCin    = ctrl_out.pc_in;
  assign IncPC   = ctrl_out.inc_pc;
  assign MARin   = ctrl_out.mar_in;
  assign MDRin   = ctrl_out.mdr_in;
  assign MDRout  = ctrl_out.mdr_out;
  assign IRin    = ctrl_out.ir_in;
  assign Yin     = ctrl_out.y_in;
  assign Zin     = ctrl_out.z_in;
  assign Zlowout = ctrl_out.zlow_out;
  assign Cout    = ctrl_out.c_out;
  assign Read    = ctrl_out.read;
  assign Write   = ctrl_out.write;
  assign Gra     = ctrl_out.gra;
  assign Grb     = ctrl_out.grb;
  assign Grc     = ctrl_out.grc;
  assign Rin     = ctrl_out.r_in;
  assign Rout    = ctrl_out.r_out;
  assign BAout   = ctrl_out.ba_out;
  assign CONin   = ctrl_out.con_in;

endmodule
